categorical_sampler: RTL and testbench

Consumes the 16-bit pseudo-random word from the LFSR stage and draws one index from a programmable categorical distribution. It is used for the transition and observation sampling in the POMDP simulator. The distribution is held as N_OUT probabilities in Q0.16, with 65536 representing 1.0. On each accepted request the block latches the random word. It then walks the cumulative sum, one entry per cycle, and returns the first index whose cumulative probability exceeds the random value.

---
 rtl/pomdp_sampler_pkg.sv | 16 +
 rtl/categorical_prob_table.sv | 34 +++
 rtl/categorical_sampler.sv | 107 ++++++++++
 tb/tb_categorical_sampler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pomdp_sampler_pkg.sv
// Shared types and defaults for the POMDP sampling stages (LFSR, categorical sampler, belief update).
package pomdp_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } sampler_state_e;

  // 1.0 in Q0.16
  localparam logic [16:0] PROB_ONE = 17'h10000;

  localparam int N_OUT_DEF  = 8;
  localparam int PROB_W_DEF = 16;

endpackage

// File: rtl/categorical_prob_table.sv
// N_OUT x PROB_W probability register file; writes accepted only while the sampler is idle.
module categorical_prob_table
  import pomdp_sampler_pkg::*;
#(
  parameter int N_OUT  = N_OUT_DEF,
  parameter int PROB_W = PROB_W_DEF,
  localparam int IDX_W = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idle,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [PROB_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [PROB_W-1:0] rd_data
);

  logic [PROB_W-1:0] mem [N_OUT];

  // Per-entry decode keeps out-of-range addresses harmless when N_OUT is not a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OUT; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (wr_en && idle && (wr_addr == IDX_W'(i))) mem[i] <= wr_data;
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/categorical_sampler.sv
// Draws one index from a programmable Q0.16 categorical distribution by a serial cumulative-sum walk.
module categorical_sampler
  import pomdp_sampler_pkg::*;
#(
  parameter int N_OUT  = N_OUT_DEF,
  parameter int PROB_W = PROB_W_DEF,
  localparam int IDX_W = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROB_W-1:0] rand_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              prob_wr_en,
  input  logic [IDX_W-1:0]  prob_wr_addr,
  input  logic [PROB_W-1:0] prob_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_fallback,
  output logic              busy
);

  // Wide enough to sum N_OUT full-scale entries without wrapping.
  localparam int ACC_W = PROB_W + IDX_W + 1;

  sampler_state_e    state, state_nxt;
  logic [PROB_W-1:0] thr;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [IDX_W-1:0]  idx;
  logic [PROB_W-1:0] prob_rd;
  logic              hit;
  logic              last;

  categorical_prob_table #(
    .N_OUT  (N_OUT),
    .PROB_W (PROB_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .idle    (state == IDLE),
    .wr_en   (prob_wr_en),
    .wr_addr (prob_wr_addr),
    .wr_data (prob_wr_data),
    .rd_idx  (idx),
    .rd_data (prob_rd)
  );

  assign acc_next = acc + ACC_W'(prob_rd);
  assign hit      = ACC_W'(thr) < acc_next;
  assign last     = (idx == IDX_W'(N_OUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = SCAN;
      SCAN:    if (hit || last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Scan datapath and result registers; results hold through DONE until the next draw overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr          <= '0;
      acc          <= '0;
      idx          <= '0;
      out_idx      <= '0;
      out_fallback <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            thr <= rand_data;
            acc <= '0;
            idx <= '0;
          end
        end
        SCAN: begin
          if (hit) begin
            out_idx      <= idx;
            out_fallback <= 1'b0;
          end else if (last) begin
            out_idx      <= idx;
            out_fallback <= 1'b1;
          end else begin
            acc <= acc_next;
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SCAN) || (state == DONE);

endmodule

// File: tb/tb_categorical_sampler.sv
// Directed-vector bench for categorical_sampler with hand-computed indices, flags and latencies.
module tb_categorical_sampler;

  typedef logic [15:0] tbl_t [8];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rand_data = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        prob_wr_en = 1'b0;
  logic [2:0]  prob_wr_addr = '0;
  logic [15:0] prob_wr_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_idx;
  logic        out_fallback;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  categorical_sampler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rand_data    (rand_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .prob_wr_en   (prob_wr_en),
    .prob_wr_addr (prob_wr_addr),
    .prob_wr_data (prob_wr_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_fallback (out_fallback),
    .busy         (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
    $fatal(1);
  end

  task automatic program_table(input tbl_t t);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      prob_wr_en = 1'b1; prob_wr_addr = 3'(i); prob_wr_data = t[i];
    end
    @(negedge clk);
    prob_wr_en = 1'b0;
  endtask

  // wr_mode: 0 none, 1 write entry 0 during first SCAN cycle, 2 write entry 0 with the request
  task automatic draw(input logic [15:0] r, input bit ack, input int wr_mode, input logic [15:0] wd,
                      output int lat, output logic [2:0] idx, output logic fb);
    @(negedge clk);
    req_valid = 1'b1; rand_data = r;
    if (wr_mode == 2) begin prob_wr_en = 1'b1; prob_wr_addr = 3'd0; prob_wr_data = wd; end
    @(negedge clk);
    req_valid = 1'b0; rand_data = ~r;
    prob_wr_en = (wr_mode == 1); prob_wr_addr = 3'd0; prob_wr_data = wd;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      prob_wr_en = 1'b0;
      lat++;
    end
    prob_wr_en = 1'b0;
    idx = out_idx; fb = out_fallback;
    if (ack) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
    checks++; if (out_fallback !== 1'b0) begin errors++; $display("FAIL reset_fallback: got %b expected 0", out_fallback); end
  endtask

  task automatic test_fallback();
    int lat; logic [2:0] idx; logic fb; tbl_t t;
    logic [15:0] rv [3]  = '{16'h0000, 16'h1000, 16'h0FFF};
    logic [2:0]  ei [3]  = '{3'd7, 3'd7, 3'd0};
    logic        ef [3]  = '{1'b1, 1'b1, 1'b0};
    int          el [3]  = '{8, 8, 1};
    for (int v = 0; v < 3; v++) begin
      if (v == 1) begin t = '{16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}; program_table(t); end
      draw(rv[v], 1'b1, 0, 16'h0, lat, idx, fb);
      checks++; if (idx !== ei[v]) begin errors++; $display("FAIL fallback_idx[%0d]: got %0d expected %0d", v, idx, ei[v]); end
      checks++; if (fb !== ef[v]) begin errors++; $display("FAIL fallback_flag[%0d]: got %b expected %b", v, fb, ef[v]); end
      checks++; if (lat != el[v]) begin errors++; $display("FAIL fallback_lat[%0d]: got %0d expected %0d", v, lat, el[v]); end
    end
  endtask

  task automatic test_uniform();
    int lat; logic [2:0] idx; logic fb; tbl_t t;
    logic [15:0] rv [4] = '{16'h0000, 16'h3FFF, 16'h4000, 16'hFFFF};
    logic [2:0]  ei [4] = '{3'd0, 3'd0, 3'd1, 3'd3};
    int          el [4] = '{1, 1, 2, 4};
    t = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0};
    program_table(t);
    for (int v = 0; v < 4; v++) begin
      draw(rv[v], 1'b1, 0, 16'h0, lat, idx, fb);
      checks++; if (idx !== ei[v]) begin errors++; $display("FAIL uniform_idx[%0d]: got %0d expected %0d", v, idx, ei[v]); end
      checks++; if (fb !== 1'b0) begin errors++; $display("FAIL uniform_flag[%0d]: got %b expected 0", v, fb); end
      checks++; if (lat != el[v]) begin errors++; $display("FAIL uniform_lat[%0d]: got %0d expected %0d", v, lat, el[v]); end
    end
  endtask

  task automatic test_sparse();
    int lat; logic [2:0] idx; logic fb; tbl_t t;
    t = '{16'h0, 16'h0, 16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0};
    program_table(t);
    draw(16'h0000, 1'b1, 0, 16'h0, lat, idx, fb);
    checks++; if (idx !== 3'd2) begin errors++; $display("FAIL sparse_idx_a: got %0d expected 2", idx); end
    checks++; if (lat != 3) begin errors++; $display("FAIL sparse_lat_a: got %0d expected 3", lat); end
    draw(16'h8000, 1'b1, 0, 16'h0, lat, idx, fb);
    checks++; if (idx !== 3'd3) begin errors++; $display("FAIL sparse_idx_b: got %0d expected 3", idx); end
    checks++; if (fb !== 1'b0) begin errors++; $display("FAIL sparse_flag_b: got %b expected 0", fb); end
    checks++; if (lat != 4) begin errors++; $display("FAIL sparse_lat_b: got %0d expected 4", lat); end
  endtask

  task automatic test_oversum();
    int lat; logic [2:0] idx; logic fb; tbl_t t;
    t = '{default: 16'hFFFF};
    program_table(t);
    draw(16'hFFFF, 1'b1, 0, 16'h0, lat, idx, fb);
    checks++; if (idx !== 3'd1) begin errors++; $display("FAIL oversum_idx: got %0d expected 1", idx); end
    checks++; if (fb !== 1'b0) begin errors++; $display("FAIL oversum_flag: got %b expected 0", fb); end
    checks++; if (lat != 2) begin errors++; $display("FAIL oversum_lat: got %0d expected 2", lat); end
  endtask

  task automatic test_backpressure();
    int lat; logic [2:0] idx; logic fb; tbl_t t;
    t = '{16'h0, 16'h0, 16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0};
    program_table(t);
    draw(16'h0000, 1'b0, 0, 16'h0, lat, idx, fb);
    checks++; if (lat != 3) begin errors++; $display("FAIL bp_lat: got %0d expected 3", lat); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, out_valid); end
      checks++; if (out_idx !== 3'd2) begin errors++; $display("FAIL bp_idx[%0d]: got %0d expected 2", c, out_idx); end
      checks++; if (out_fallback !== 1'b0) begin errors++; $display("FAIL bp_flag[%0d]: got %b expected 0", c, out_fallback); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", c, req_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %b expected 1", c, busy); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_table_write();
    int lat; logic [2:0] idx; logic fb;
    draw(16'h0000, 1'b1, 1, 16'hFFFF, lat, idx, fb);
    checks++; if (idx !== 3'd2) begin errors++; $display("FAIL wr_scan_idx: got %0d expected 2", idx); end
    draw(16'h0000, 1'b1, 0, 16'h0, lat, idx, fb);
    checks++; if (idx !== 3'd2) begin errors++; $display("FAIL wr_scan_next_idx: got %0d expected 2", idx); end
    @(negedge clk);
    prob_wr_en = 1'b1; prob_wr_addr = 3'd0; prob_wr_data = 16'hFFFF;
    @(negedge clk);
    prob_wr_en = 1'b0;
    draw(16'h0000, 1'b1, 0, 16'h0, lat, idx, fb);
    checks++; if (idx !== 3'd0) begin errors++; $display("FAIL wr_idle_idx: got %0d expected 0", idx); end
    checks++; if (lat != 1) begin errors++; $display("FAIL wr_idle_lat: got %0d expected 1", lat); end
    draw(16'h0000, 1'b1, 2, 16'h0000, lat, idx, fb);
    checks++; if (idx !== 3'd2) begin errors++; $display("FAIL wr_with_req_idx: got %0d expected 2", idx); end
    checks++; if (lat != 3) begin errors++; $display("FAIL wr_with_req_lat: got %0d expected 3", lat); end
  endtask

  task automatic test_reset_mid_scan();
    int lat; logic [2:0] idx; logic fb; bit seen;
    @(negedge clk);
    req_valid = 1'b1; rand_data = 16'hFFFF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_scan_busy: got %b expected 1", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_scan_valid: got %b expected 0", out_valid); end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_result: got %b expected 0", seen); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
    draw(16'h0000, 1'b1, 0, 16'h0, lat, idx, fb);
    checks++; if (idx !== 3'd7) begin errors++; $display("FAIL rst_cleared_idx: got %0d expected 7", idx); end
    checks++; if (fb !== 1'b1) begin errors++; $display("FAIL rst_cleared_flag: got %b expected 1", fb); end
    checks++; if (lat != 8) begin errors++; $display("FAIL rst_cleared_lat: got %0d expected 8", lat); end
  endtask

  initial begin
    test_reset();
    test_fallback();
    test_uniform();
    test_sparse();
    test_oversum();
    test_backpressure();
    test_table_write();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
